// File: rtl/framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_arbiter
// Brief    : Single-port framebuffer arbiter: scanout reads > pixel writer >
//            frame-clear engine, with registered memory command.
// Revision : 1.0  initial release
// ============================================================================
module framebuffer_arbiter #(
    parameter int                 ADDR_W    = 17,
    parameter int                 DATA_W    = 12,
    parameter int                 DEPTH     = 120000,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic               clock_162,
    input  logic               rst,
    // Scanout
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               pix_valid,
    output logic [DATA_W-1:0]  pix_data,
    // Writer
    input  logic               wr_valid,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ready,
    // Clear control
    input  logic               frame_start,
    input  logic               clear_en,
    output logic               clear_busy,
    output logic               clear_done,
    output logic               clear_overrun,
    // Memory port
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic [1:0]         r_rd_tag;
    logic               r_clear_done;
    logic               r_clear_overrun;

    logic               w_wr_accept;
    logic               w_clr_grant;
    logic               w_clr_last;

    // Scanout owns any cycle it asks for; the writer only sees what is left.
    assign wr_ready    = !rd_req && !rst;
    assign w_wr_accept = wr_valid && wr_ready;
    assign w_clr_grant = (r_state == ST_CLEAR) && !rd_req && !w_wr_accept;
    assign w_clr_last  = (r_clr_addr == c_last_addr);

    assign clear_busy    = (r_state == ST_CLEAR);
    assign clear_done    = r_clear_done;
    assign clear_overrun = r_clear_overrun;

    // Clear engine
    always_ff @(posedge clock_162) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_clr_addr      <= '0;
            r_clear_done    <= 1'b0;
            r_clear_overrun <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_start && clear_en) begin
                        r_state    <= ST_CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (frame_start) begin
                        r_clear_overrun <= 1'b1;
                    end
                    if (w_clr_grant) begin
                        if (w_clr_last) begin
                            r_state      <= ST_IDLE;
                            r_clear_done <= 1'b1;
                        end else begin
                            r_clr_addr <= r_clr_addr + c_addr_one;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Registered memory command; address/data hold when the port is idle.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (rd_req) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_addr;
        end else if (w_wr_accept) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
        end else if (w_clr_grant) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= r_clr_addr;
            mem_wdata <= CLEAR_VAL;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    // Tag pipe tracks reads through the command register and RAM latency.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            r_rd_tag  <= 2'b00;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            r_rd_tag  <= {r_rd_tag[0], rd_req};
            pix_valid <= r_rd_tag[1];
            if (r_rd_tag[1]) begin
                pix_data <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Single-port framebuffer arbiter between the VGA scanout path, the physics-engine pixel writer and a frame-clear engine. It sits between the 1600x1200@60 Hz VGA driver (clock_162 domain) and one synchronous single-port RAM holding a 400x300, 12-bit framebuffer that is displayed at 4x scale. Scanout reads are never delayed. The writer and the clear engine share the remaining memory cycles.

## Interface
- ADDR_W, 17, framebuffer address width
- DATA_W, 12, pixel width ({R,G,B} 4 bits each)
- DEPTH, 120000, number of framebuffer words (400*300)
- CLEAR_VAL, 12'h000, value written by the clear engine
- Clock and reset:
  - clock_162  in  1  pixel clock, all logic rising-edge
  - rst  in  1  synchronous, active-high reset
- Scanout:
  - rd_req  in  1  scanout read request (upstream guarantees at most one per 2 cycles)
  - rd_addr  in  ADDR_W  scanout address
  - pix_valid  out  1  pixel response valid
  - pix_data  out  DATA_W  pixel response
- Writer:
  - wr_valid  in  1  writer has a pixel
  - wr_addr  in  ADDR_W  write address
  - wr_data  in  DATA_W  write data
  - wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready
- Clear control:
  - frame_start  in  1  one-cycle pulse at frame boundary
  - clear_en  in  1  frame_start launches a clear when high
  - clear_busy  out  1  clear engine active
  - clear_done  out  1  one-cycle pulse after the last clear write is issued
  - clear_overrun  out  1  sticky flag: frame_start arrived while busy
- Memory port:
  - mem_en  out  1  memory access
  - mem_we  out  1  write strobe
  - mem_addr  out  ADDR_W  memory address
  - mem_wdata  out  DATA_W  write data
  - mem_rdata  in  DATA_W  read data, valid 1 cycle after a read is presented

## Operation
- Fixed priority per cycle: scanout > writer > clear.
- wr_ready = !rd_req && !rst. This is combinational and independent of clear_busy.
- The clear engine issues a write only in a cycle with no rd_req and no accepted write.
- Clear FSM:
  - IDLE → CLEAR on frame_start && clear_en. Loads clr_addr = 0.
  - In CLEAR, each granted clear slot writes CLEAR_VAL to clr_addr, then increments clr_addr.
  - The granted slot with clr_addr == DEPTH-1 returns the FSM to IDLE and pulses clear_done in the following cycle.
  - frame_start in CLEAR is ignored and sets clear_overrun. clear_overrun clears only on rst.
  - frame_start with clear_en low does nothing.
- Writer/clear interaction:
  - A write to an address below the current clr_addr persists.
  - A write at or above clr_addr is overwritten later by the clear. This is intended behaviour.
- Address range:
  - rd_addr >= DEPTH and wr_addr >= DEPTH are passed through unmodified; the RAM ignores them.
  - clr_addr never exceeds DEPTH-1.
- Memory command:
  - Registered: the command selected in cycle t drives mem_* in cycle t+1.
  - mem_en = 0 in idle cycles. mem_we = 1 only for writer and clear commands.
- Scanout response:
  - A 2-bit shift register tags read commands.
  - mem_rdata is captured in cycle t+2.
  - pix_valid and pix_data are registered and asserted in cycle t+3.
  - pix_data holds its last value when pix_valid = 0.

## Timing
- Read latency is rd_req at edge t → pix_valid high in cycle t+3. Throughput is one read per 2 cycles.
- An accepted write reaches the RAM in cycle t+1.
- Full-array clear with no other traffic takes DEPTH cycles: clear_busy is high for DEPTH cycles, then clear_done pulses.
- Reset values:
  - pix_valid = 0, pix_data = 0
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - clear_busy = 0, clear_done = 0, clear_overrun = 0
  - FSM = IDLE, read tag pipe = 0
- Reset mid-operation:
  - rst during CLEAR aborts immediately. clear_busy = 0 next cycle and no clear_done pulse.
  - Read responses in flight are dropped.
- Simultaneous events:
  - rd_req with wr_valid: the read wins, wr_ready = 0 and the write stalls.
  - frame_start in the cycle the last clear slot is granted counts as "in CLEAR". It sets the overrun flag and does not restart the clear.

## Test plan
- Scanout only:
  - Stimulus: preload RAM[5] = 12'hABC, then rd_req with rd_addr = 5 at cycle 10.
  - Required: pix_valid in cycle 13 with pix_data = 12'hABC; mem_we = 0 throughout.
- Collision:
  - Stimulus: rd_req and wr_valid (addr 7, data 12'h123) in the same cycle.
  - Required: wr_ready = 0 in that cycle. Next cycle, with rd_req low, wr_ready = 1 and mem_we = 1, mem_addr = 7 in the following cycle.
- Full clear (DEPTH = 16 in the bench):
  - Stimulus: frame_start with clear_en = 1.
  - Required: 16 writes of CLEAR_VAL at addresses 0..15 in order, clear_busy high for 16 cycles, then one clear_done pulse.
- Clear under traffic:
  - Stimulus: rd_req every 2 cycles plus a continuous writer during a clear.
  - Required: no read is delayed, writes take every free slot, and the clear only advances in slots nobody else uses.
  - Required: once traffic stops, the clear finishes with every address 0..15 written exactly once.
- Overrun:
  - Stimulus: a second frame_start while clear_busy is high.
  - Required: clear_overrun = 1 and stays 1, and the clear address is not reset.
- Reset mid-clear:
  - Stimulus: rst at clr_addr = 9.
  - Required: all outputs return to their reset values, no clear_done pulse, and the next frame_start clears again from address 0.
